// File: rtl/paddle_array_ctrl.sv
// Paddle array controller: N_PAD independent paddles with tick-paced,
// accelerating movement clamped to the playfield.
//
// Ports:
//   CLK     system clock, rising edge
//   RST     synchronous active-high reset
//   EN      run enable; low pauses all paddles
//   CENTER  recentre all paddles on the next edge
//   UP      per-paddle up buttons (bit i -> paddle i)
//   DOWN    per-paddle down buttons
//   POS     packed top-row positions, paddle i at [i*POS_W +: POS_W]
//   AT_TOP  paddle i at top limit
//   AT_BOT  paddle i at bottom limit
//   MOVING  paddle i not idle
module paddle_array_ctrl #(
    parameter int N_PAD       = 2,
    parameter int SCR_H       = 20,
    parameter int PADDLE_H    = 6,
    parameter int POS_W       = 11,
    parameter int TICK_DIV    = 4,
    parameter int ACCEL_TICKS = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   CENTER,
    input  logic [N_PAD-1:0]       UP,
    input  logic [N_PAD-1:0]       DOWN,
    output logic [N_PAD*POS_W-1:0] POS,
    output logic [N_PAD-1:0]       AT_TOP,
    output logic [N_PAD-1:0]       AT_BOT,
    output logic [N_PAD-1:0]       MOVING
);

    localparam logic [POS_W-1:0] POS_MIN = POS_W'(1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(SCR_H - 1 - PADDLE_H);
    localparam logic [POS_W-1:0] POS_CTR = POS_W'((SCR_H - PADDLE_H) / 2);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        UP_SLOW,
        DOWN_SLOW,
        UP_FAST,
        DOWN_FAST
    } state_t;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    // With TICK_DIV=1 the counter stays at 0 and tick is permanently high.
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_PAD; g++) begin : g_pad
        state_t            state_q;
        state_t            state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic [HOLD_W-1:0] hold_inc;
        logic [POS_W-1:0]  pos_q;
        logic [POS_W-1:0]  pos_d;
        logic [POS_W-1:0]  step;
        logic              req_up;
        logic              req_dn;
        logic              cur_up;
        logic              cur_dn;
        logic              same_dir;
        logic              blocked;
        logic              fast;

        assign req_up = UP[g] & ~DOWN[g];
        assign req_dn = DOWN[g] & ~UP[g];
        assign cur_up = (state_q == UP_SLOW) || (state_q == UP_FAST);
        assign cur_dn = (state_q == DOWN_SLOW) || (state_q == DOWN_FAST);

        assign same_dir = (req_up & cur_up) | (req_dn & cur_dn);

        // A request pushing into a limit is a no-op: state and hold stay.
        assign blocked = (req_up & (pos_q <= POS_MIN)) |
                         (req_dn & (pos_q >= POS_MAX));

        always_ff @(posedge CLK) begin
            if (RST || CENTER) begin
                state_q <= IDLE;
                hold_q  <= '0;
                pos_q   <= POS_CTR;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                pos_q   <= pos_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            pos_d    = pos_q;
            hold_inc = HOLD_W'(1);
            fast     = 1'b0;
            step     = POS_W'(1);
            if (!EN) begin
                state_d = IDLE;
                hold_d  = '0;
            end else if (tick) begin
                if (!req_up && !req_dn) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (!blocked) begin
                    if (same_dir) begin
                        hold_inc = (hold_q >= HOLD_MAX) ? HOLD_MAX
                                                        : hold_q + HOLD_W'(1);
                        fast     = (hold_inc == HOLD_MAX);
                    end
                    hold_d = hold_inc;
                    step   = fast ? POS_W'(2) : POS_W'(1);
                    if (req_up) begin
                        state_d = fast ? UP_FAST : UP_SLOW;
                        pos_d   = ((pos_q - POS_MIN) < step) ? POS_MIN
                                                             : pos_q - step;
                    end else begin
                        state_d = fast ? DOWN_FAST : DOWN_SLOW;
                        pos_d   = ((POS_MAX - pos_q) < step) ? POS_MAX
                                                             : pos_q + step;
                    end
                end
            end
        end

        assign POS[g*POS_W +: POS_W] = pos_q;
        assign AT_TOP[g] = (pos_q == POS_MIN);
        assign AT_BOT[g] = (pos_q == POS_MAX);
        assign MOVING[g] = (state_q != IDLE);
    end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Testbench for paddle_array_ctrl: directed button sequences checked every
// cycle against a position/direction model, plus literal expectations.
module tb_paddle_array_ctrl;

    localparam int N    = 2;
    localparam int SH   = 20;
    localparam int PH   = 6;
    localparam int PW   = 11;
    localparam int TD   = 4;
    localparam int AT   = 3;
    localparam int PMIN = 1;
    localparam int PMAX = SH - 1 - PH;
    localparam int PCTR = (SH - PH) / 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          CENTER;
    logic [N-1:0]  UP;
    logic [N-1:0]  DOWN;
    logic [N*PW-1:0] POS;
    logic [N-1:0]  AT_TOP;
    logic [N-1:0]  AT_BOT;
    logic [N-1:0]  MOVING;

    always #5 CLK = ~CLK;

    paddle_array_ctrl #(
        .N_PAD(N), .SCR_H(SH), .PADDLE_H(PH), .POS_W(PW),
        .TICK_DIV(TD), .ACCEL_TICKS(AT)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CENTER(CENTER),
        .UP(UP), .DOWN(DOWN), .POS(POS),
        .AT_TOP(AT_TOP), .AT_BOT(AT_BOT), .MOVING(MOVING)
    );

    // Model: position, direction (-1 up, +1 down, 0 idle), run length.
    int m_pos[N];
    int m_dir[N];
    int m_hold[N];
    int m_tc;
    bit m_tick;
    int rq;
    int st;

    int n_chk  = 0;
    int n_fail = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_tc   = 0;
            m_tick = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_pos[i]  = PCTR;
                m_dir[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            m_tick = (m_tc == TD - 1);
            m_tc   = (m_tc + 1) % TD;
            for (int i = 0; i < N; i++) begin
                rq = (UP[i] && !DOWN[i]) ? -1 :
                     (DOWN[i] && !UP[i]) ? 1 : 0;
                if (CENTER) begin
                    m_pos[i]  = PCTR;
                    m_dir[i]  = 0;
                    m_hold[i] = 0;
                end else if (!EN) begin
                    m_dir[i]  = 0;
                    m_hold[i] = 0;
                end else if (m_tick) begin
                    if (rq == 0) begin
                        m_dir[i]  = 0;
                        m_hold[i] = 0;
                    end else if (m_pos[i] + rq >= PMIN &&
                                 m_pos[i] + rq <= PMAX) begin
                        if (rq == m_dir[i]) begin
                            m_hold[i] = (m_hold[i] + 1 > AT) ? AT
                                                             : m_hold[i] + 1;
                            st = (m_hold[i] >= AT) ? 2 : 1;
                        end else begin
                            m_hold[i] = 1;
                            st = 1;
                        end
                        m_pos[i] = m_pos[i] + rq * st;
                        if (m_pos[i] < PMIN) m_pos[i] = PMIN;
                        if (m_pos[i] > PMAX) m_pos[i] = PMAX;
                        m_dir[i] = rq;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic cyc();
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pos%0d", i), int'(POS[i*PW +: PW]), m_pos[i]);
            chk($sformatf("at_top%0d", i), int'(AT_TOP[i]),
                int'(m_pos[i] == PMIN));
            chk($sformatf("at_bot%0d", i), int'(AT_BOT[i]),
                int'(m_pos[i] == PMAX));
            chk($sformatf("moving%0d", i), int'(MOVING[i]),
                int'(m_dir[i] != 0));
        end
    endtask

    task automatic next_tick();
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!m_tick && k < 3 * TD);
        chk("tick_seen", int'(m_tick), 1);
    endtask

    function automatic int p(input int i);
        return int'(POS[i*PW +: PW]);
    endfunction

    initial begin
        RST = 1'b1;
        EN = 1'b1;
        CENTER = 1'b0;
        UP = '0;
        DOWN = '0;
        repeat (3) cyc();
        chk("rst_pos0", p(0), 7);
        chk("rst_pos1", p(1), 7);
        chk("rst_moving", int'(MOVING), 0);
        RST = 1'b0;

        // Idle after reset
        repeat (20) cyc();
        chk("idle_pos0", p(0), 7);
        chk("idle_pos1", p(1), 7);
        chk("idle_top", int'(AT_TOP), 0);
        chk("idle_bot", int'(AT_BOT), 0);
        chk("idle_moving", int'(MOVING), 0);

        // Hold UP[0]: 6, 5, 3, 1, 1
        UP = 2'b01;
        repeat (3) cyc();
        chk("pre_tick_pos0", p(0), 7);
        cyc();
        chk("up_t1", p(0), 6);
        next_tick();
        chk("up_t2", p(0), 5);
        next_tick();
        chk("up_t3", p(0), 3);
        chk("up_t3_top", int'(AT_TOP[0]), 0);
        next_tick();
        chk("up_t4", p(0), 1);
        chk("up_t4_top", int'(AT_TOP[0]), 1);
        next_tick();
        chk("up_t5", p(0), 1);
        chk("up_t5_moving", int'(MOVING[0]), 1);
        chk("up_pos1", p(1), 7);

        // Both buttons while fast -> idle, then slow restart
        UP = '0;
        CENTER = 1'b1;
        cyc();
        CENTER = 1'b0;
        chk("ctr_pos0", p(0), 7);
        UP = 2'b01;
        next_tick();
        next_tick();
        next_tick();
        chk("fast_pos0", p(0), 3);
        DOWN = 2'b01;
        next_tick();
        chk("both_pos0", p(0), 3);
        chk("both_moving", int'(MOVING[0]), 0);
        DOWN = '0;
        next_tick();
        chk("restart_pos0", p(0), 2);

        // Independent paddles, paddle 1 clamps at bottom from fast
        UP = '0;
        CENTER = 1'b1;
        cyc();
        CENTER = 1'b0;
        UP = 2'b11;
        next_tick();
        chk("ind_pos0", p(0), 6);
        chk("ind_pos1", p(1), 6);
        UP = 2'b01;
        DOWN = 2'b10;
        next_tick();
        chk("dn_p1_a", p(1), 7);
        chk("dn_p0_a", p(0), 5);
        next_tick();
        chk("dn_p1_b", p(1), 8);
        next_tick();
        chk("dn_p1_c", p(1), 10);
        next_tick();
        chk("dn_p1_d", p(1), 12);
        chk("dn_p1_d_bot", int'(AT_BOT[1]), 0);
        next_tick();
        chk("clamp_p1", p(1), 13);
        chk("clamp_bot1", int'(AT_BOT[1]), 1);
        chk("clamp_p0", p(0), 1);

        // Pause freezes position; resume starts slow
        UP = '0;
        DOWN = '0;
        CENTER = 1'b1;
        cyc();
        CENTER = 1'b0;
        EN = 1'b0;
        DOWN = 2'b01;
        repeat (3) next_tick();
        chk("pause_pos0", p(0), 7);
        chk("pause_moving", int'(MOVING[0]), 0);
        EN = 1'b1;
        next_tick();
        chk("resume_a", p(0), 8);
        next_tick();
        chk("resume_b", p(0), 9);
        next_tick();
        chk("resume_c", p(0), 11);

        // CENTER then RST mid-move
        cyc();
        cyc();
        CENTER = 1'b1;
        cyc();
        CENTER = 1'b0;
        chk("midctr_pos0", p(0), 7);
        chk("midctr_pos1", p(1), 7);
        chk("midctr_moving", int'(MOVING), 0);
        next_tick();
        chk("postctr_pos0", p(0), 8);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("midrst_pos0", p(0), 7);
        chk("midrst_moving", int'(MOVING), 0);
        repeat (3) cyc();
        chk("postrst_wait", p(0), 7);
        cyc();
        chk("postrst_tick", p(0), 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
